pipe_stage_elastic: RTL and testbench

//  Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_elastic.sv | 100 ++++++++++
 tb/tb_pipe_stage_elastic.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register for a stage boundary: valid/ready handshake, optional skid entry,
// synchronous flush, and stall/transfer performance counters.
module pipe_stage_elastic #(
  parameter int               WIDTH   = 32,
  parameter bit               SKID    = 1'b1,
  parameter int               CNT_W   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   xfer_q, xfer_d;
  logic               in_fire, out_fire;

  always_comb begin
    out_valid = (state_q != S_EMPTY);
    // in_ready is held low during reset so nothing is accepted before the first edge after release
    if (SKID) in_ready = (state_q != S_SKID) & ~flush & reset;
    else      in_ready = ((state_q == S_EMPTY) | out_ready) & ~flush & reset;
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready & ~flush;

    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          state_d = S_FULL;
          main_d  = in_data;
        end
      end
      S_FULL: begin
        if (in_fire && out_ready) begin
          main_d = in_data;
        end else if (in_fire && SKID) begin
          state_d = S_SKID;
          skid_d  = in_data;
        end else if (out_ready) begin
          state_d = S_EMPTY;
        end
      end
      S_SKID: begin
        if (out_ready) begin
          state_d = S_FULL;
          main_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    if (flush) begin
      state_d = S_EMPTY;
      main_d  = RST_VAL;
      skid_d  = RST_VAL;
    end

    stall_d = stall_q;
    if (out_valid && !out_ready && !flush && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
    xfer_d = xfer_q;
    if (out_fire) xfer_d = xfer_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
      stall_q <= '0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
      xfer_q  <= xfer_d;
    end
  end

  assign out_data  = main_q;
  assign stall_cnt = stall_q;
  assign xfer_cnt  = xfer_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a skid instance and a single-entry 2-bit-counter instance share
// one stimulus stream; each has its own scoreboard queue and counter model.
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [15:0] a_stall, a_xfer;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [1:0]  b_stall, b_xfer;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int ea_xfer, ea_stall, eb_xfer, eb_stall;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.WIDTH(32), .SKID(1'b1), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .stall_cnt(a_stall), .xfer_cnt(a_xfer)
  );

  pipe_stage_elastic #(.WIDTH(32), .SKID(1'b0), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .stall_cnt(b_stall), .xfer_cnt(b_xfer)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: handshakes are sampled at the falling edge, mid-cycle, when inputs are settled.
  always @(negedge clk) begin
    if (!reset) begin
      qa.delete(); ea_xfer = 0; ea_stall = 0;
    end else begin
      if (a_out_valid && out_ready && !flush) begin
        if (qa.size() == 0) chk("a_sb_underflow", 32'd1, 32'd0);
        else chk("a_sb_data", a_out_data, qa.pop_front());
        ea_xfer++;
      end
      if (a_out_valid && !out_ready && !flush) ea_stall++;
      if (flush) qa.delete();
      else if (in_valid && a_in_ready) qa.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      qb.delete(); eb_xfer = 0; eb_stall = 0;
    end else begin
      if (b_out_valid && out_ready && !flush) begin
        if (qb.size() == 0) chk("b_sb_underflow", 32'd1, 32'd0);
        else chk("b_sb_data", b_out_data, qb.pop_front());
        eb_xfer++;
      end
      if (b_out_valid && !out_ready && !flush) eb_stall++;
      if (flush) qb.delete();
      else if (in_valid && b_in_ready) qb.push_back(in_data);
    end
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;

    // reset held with input offered
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_in_ready",  32'(a_in_ready),  32'd0);
    chk("rst_in_ready_b", 32'(b_in_ready), 32'd0);
    chk("rst_out_data",  a_out_data, 32'd0);
    chk("rst_stall",     32'(a_stall), 32'd0);
    chk("rst_xfer",      32'(a_xfer),  32'd0);
    tick(); reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 32'(a_in_ready), 32'd1);

    // streaming
    tick(); in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b1;
    tick(); in_data = 32'h22;
    @(negedge clk); chk("str_d0", a_out_data, 32'h11);
    tick(); in_data = 32'h33;
    @(negedge clk); chk("str_d1", a_out_data, 32'h22);
    tick(); in_valid = 1'b0;
    @(negedge clk); chk("str_d2", a_out_data, 32'h33);
    tick();
    @(negedge clk);
    chk("str_empty", 32'(a_out_valid), 32'd0);
    chk("str_xfer",  32'(a_xfer), 32'd3);

    // stall into skid, then release
    tick(); in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b0;
    tick(); in_data = 32'hB;
    @(negedge clk); chk("stl_rdy_full", 32'(a_in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    @(negedge clk); chk("stl_hold0", a_out_data, 32'hA);
    tick();
    @(negedge clk); chk("stl_hold1", a_out_data, 32'hA);
    tick(); out_ready = 1'b1;
    @(negedge clk);
    chk("stl_rdy_skid", 32'(a_in_ready), 32'd0);
    chk("stl_hold2",    a_out_data, 32'hA);
    chk("stl_valid",    32'(a_out_valid), 32'd1);
    chk("stl_cnt",      32'(a_stall), 32'd3);
    tick();
    @(negedge clk); chk("stl_rel_b", a_out_data, 32'hB);
    tick();
    @(negedge clk);
    chk("stl_drained", 32'(a_out_valid), 32'd0);
    chk("stl_xfer",    32'(a_xfer), 32'd5);

    // flush while holding two entries, with a new input offered
    tick(); in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b0;
    tick(); in_data = 32'hB;
    tick(); flush = 1'b1; in_data = 32'hC; out_ready = 1'b1;
    @(negedge clk);
    chk("fl_in_ready", 32'(a_in_ready), 32'd0);
    chk("fl_in_ready_b", 32'(b_in_ready), 32'd0);
    tick(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fl_valid", 32'(a_out_valid), 32'd0);
    chk("fl_data",  a_out_data, 32'd0);
    chk("fl_xfer",  32'(a_xfer), 32'd5);
    repeat (3) tick();
    @(negedge clk);
    chk("fl_nodeliver", 32'(a_out_valid), 32'd0);
    chk("fl_xfer2",     32'(a_xfer), 32'd5);
    chk("fl_stall_kept", 32'(a_stall), 32'd4);

    // single-entry, 2-bit counters: saturation and wrap
    tick(); reset = 1'b0;
    tick(); reset = 1'b1; in_valid = 1'b1; in_data = 32'h50; out_ready = 1'b0;
    tick(); in_data = 32'h51;
    @(negedge clk); chk("s0_rdy_stall", 32'(b_in_ready), 32'd0);
    repeat (5) tick();
    @(negedge clk);
    chk("s0_stall_sat", 32'(b_stall), 32'd3);
    chk("s1_stall",     32'(a_stall), 32'd5);
    tick(); out_ready = 1'b1; in_data = 32'h52;
    @(negedge clk);
    chk("s0_rdy_go",    32'(b_in_ready), 32'd1);
    chk("s0_stall_sat2", 32'(b_stall), 32'd3);
    for (int k = 0; k < 4; k++) begin
      tick(); in_data = in_data + 32'd1;
    end
    tick(); out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("s0_xfer_wrap", 32'(b_xfer), 32'd1);
    chk("s1_xfer",      32'(a_xfer), 32'd5);
    tick(); out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("s_drain_a", qa.size(), 32'd0);
    chk("s_drain_b", qb.size(), 32'd0);

    // asynchronous reset between edges during a stall
    tick(); in_valid = 1'b1; in_data = 32'h66; out_ready = 1'b0;
    tick(); in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("ar_valid_a", 32'(a_out_valid), 32'd0);
    chk("ar_valid_b", 32'(b_out_valid), 32'd0);
    chk("ar_rdy_a",   32'(a_in_ready), 32'd0);
    chk("ar_data_a",  a_out_data, 32'd0);
    chk("ar_stall_a", 32'(a_stall), 32'd0);
    tick(); reset = 1'b1;

    // random soak
    repeat (400) begin
      tick();
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = $urandom;
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 15) == 0;
    end
    tick(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk); #1;
    chk("soak_drain_a", qa.size(), 32'd0);
    chk("soak_drain_b", qb.size(), 32'd0);
    chk("soak_xfer_a",  32'(a_xfer),  32'(ea_xfer & 32'hFFFF));
    chk("soak_stall_a", 32'(a_stall), (ea_stall > 65535) ? 32'hFFFF : 32'(ea_stall));
    chk("soak_xfer_b",  32'(b_xfer),  32'(eb_xfer & 3));
    chk("soak_stall_b", 32'(b_stall), (eb_stall > 3) ? 32'd3 : 32'(eb_stall));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
